ta_fifo_buffer: RTL and testbench
=================================

// Module: ta_fifo_buffer
// PURPOSE
//  Write buffer between the SH4 data port and the PVR TA FIFO input (CS4 window 0x10000000-0x107FFFFF).
//  Accepts masked 64-bit SH4 store beats and queues them in a DEPTH-entry FIFO.
//  Unpacks them into a 32-bit word stream with a valid/ready handshake, consumed by the TA front end inside pvr.
//  Tags every 8th emitted word as the end of a 32-byte TA parameter block.
//  Back-pressures the core via wr_ready when full.
// PARAMETERS
//  DEPTH  16               FIFO entries (64-bit data + 8-bit mask each); power of two, >=2
//  AW     $clog2(DEPTH)    pointer width (derived; do not override)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active high
//  flush      in   1   sync clear: empties FIFO + unpacker, resets block word count
//  wr_valid   in   1   store beat present (dm_req_valid & dm_req_wen & ta_fifo_cs)
//  wr_ready   out  1   beat accepted this cycle if wr_valid & wr_ready
//  wr_data    in   64  store data; [31:0] = low word, [63:32] = high word
//  wr_mask    in   8   byte enables; [3:0] qualify low word, [7:4] qualify high word
//  out_valid  out  1   out_data/out_last valid
//  out_ready  in   1   TA consumer accepts word when out_valid & out_ready
//  out_data   out  32  TA word
//  out_last   out  1   word is 8th of a 32-byte block
//  level      out  AW+1 FIFO occupancy in entries (excludes entry held by unpacker)
// BEHAVIOUR
//  Reset (async, rst=1): pointers, level=0, out_valid=0, out_data=0, out_last=0,
//   word count=0, unpacker IDLE, wr_ready=1 after release.
//  FIFO
//   - wr_ready = (level != DEPTH), registered; no same-cycle pass-through when full, even if popping.
//   - Pointers wrap mod DEPTH; level saturates neither way (overflow/underflow impossible by handshake).
//   - Simultaneous push+pop: level unchanged.
//   - Beat with wr_mask==8'h00 is accepted, not stored.
//  Unpacker FSM: IDLE -> LO / HI -> IDLE
//   - IDLE: if level!=0, pop entry into hold reg.
//       Go LO if mask[3:0]!=0, else HI if mask[7:4]!=0.
//   - LO: out_data=hold[31:0].
//       On handshake: HI if hold mask[7:4]!=0; else pop next entry directly (LO/HI) or go IDLE if empty.
//   - HI: out_data=hold[63:32].
//       On handshake: pop next entry directly (LO/HI) or go IDLE if empty.
//   - A word is emitted if ANY of its 4 mask bits is set; partial-byte words are passed whole.
//   - out_valid=1 exactly in LO/HI; out_data/out_last held stable until handshake.
//   - Back-to-back: one word per cycle with out_ready=1 while the FIFO is non-empty.
//  Latency: beat accepted at edge k (FIFO empty, unpacker IDLE) -> out_valid=1 after edge k+1.
//  Block tagging
//   - 3-bit word count increments on each out handshake, wraps 7->0.
//   - out_last = (count==7) for the presented word.
//  flush
//   - Beats on wr_valid in the flush cycle are dropped.
//   - After the edge: level=0, out_valid=0, count=0, IDLE.
//   - flush has priority over all other events.
//  Reset mid-operation: all state cleared asynchronously; queued data lost; no partial word emitted after release.
// TESTING
//  1. Single store 0x22222222_11111111, mask FF, out_ready=1:
//     out 0x11111111 (cycle k+1), then 0x22222222 (k+2); level returns 0.
//  2. Four FF stores back-to-back, out_ready=1:
//     8 words in order; out_last=1 only on 8th; count back to 0.
//  3. Masks 0F, F0, 00, 01:
//     exactly words lo0, hi1, lo3 emitted; mask-00 beat accepted with no output.
//  4. out_ready=0, push DEPTH+2 beats:
//     wr_ready falls after 16 stored + 1 held (17 accepted), level=16.
//     Raise out_ready: all 34 words drain in order; wr_ready reasserts one cycle after first pop.
//  5. Random out_ready toggling:
//     out_data/out_last never change while out_valid & !out_ready; stream matches scoreboard.
//  6. flush with 5 entries queued and HI state held:
//     next cycle out_valid=0, level=0; following store emits with out_last at its 8th word (count reset).
//  7. Assert rst mid-stream:
//     out_valid, level drop to 0 immediately (before next clk edge).

Source files
------------

// File: rtl/ta_fifo_buffer_if.sv
// ta_fifo_buffer_if: store-beat input and TA word output handshakes of the TA FIFO buffer
interface ta_fifo_buffer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  modport master (output wr_valid, wr_data, wr_mask, out_ready, input wr_ready, out_valid, out_data, out_last);
  modport slave (input wr_valid, wr_data, wr_mask, out_ready, output wr_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/ta_fifo_buffer.sv
// ta_fifo_buffer: queues masked 64-bit SH4 stores and unpacks them into a 32-bit TA word stream
module ta_fifo_buffer #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  ta_fifo_buffer_if.slave   bus,
  output logic [AW:0]       level
);
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  state_t state, nxt;
  logic [71:0] mem [DEPTH];
  logic [71:0] hold;
  logic [AW-1:0] wptr, rptr;
  logic [2:0] cnt;
  logic rdy, vld, push, pop, hs;
  assign rdy = level != (AW+1)'(DEPTH);
  assign vld = state != IDLE;
  assign bus.wr_ready = rdy;
  assign bus.out_valid = vld;
  assign bus.out_data = state == HI ? hold[63:32] : hold[31:0];
  assign bus.out_last = vld & (cnt == 3'd7);
  // all-zero-mask beats are handshaken but never stored; the hold entry is refilled as soon as its last word leaves
  always_comb begin
    push = bus.wr_valid & rdy & |bus.wr_mask & !flush;
    hs = vld & bus.out_ready;
    pop = (level != '0) & (state == IDLE | hs & (state == HI | hold[71:68] == 4'h0));
    nxt = pop ? (|mem[rptr][67:64] ? LO : HI)
        : (state == LO & hs & |hold[71:68]) ? HI
        : (state == IDLE | hs) ? IDLE : state;
  end
  // FIFO storage has no reset; only pointers and occupancy define its contents
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {bus.wr_mask, bus.wr_data};
  // unpacker state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= flush ? IDLE : nxt;
  // pointers, occupancy, hold register and block word count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      cnt <= '0;
      hold <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      cnt <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (pop) hold <= mem[rptr];
      if (hs) cnt <= cnt + 3'd1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: tb/tb_ta_fifo_buffer.sv
// tb_ta_fifo_buffer: directed self-checking bench for ta_fifo_buffer
module tb_ta_fifo_buffer;
  localparam int DEPTH = 16;
  logic clk = 0;
  logic rst = 1;
  logic flush = 0;
  logic [4:0] level;
  int checks = 0;
  int errors = 0;
  int wcnt = 0;
  logic [31:0] exp_q[$];
  logic pv = 0, pr = 0, pf = 1, pl = 0;
  logic [31:0] pd = 0;
  bit done = 0;
  ta_fifo_buffer_if bus();
  ta_fifo_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus), .level(level));
  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon_step();
    if (!rst) begin
      if (pv && !pr && !pf) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, pd);
        check("stall_last", bus.out_last, pl);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("word_data", bus.out_data, exp_q.pop_front());
        check("word_last", bus.out_last, wcnt == 7);
        wcnt = (wcnt + 1) % 8;
      end
    end
    pv = bus.out_valid;
    pr = bus.out_ready;
    pf = flush | rst;
    pd = bus.out_data;
    pl = bus.out_last;
  endtask

  task automatic push(logic [63:0] d, logic [7:0] m);
    int n = 0;
    bus.wr_valid = 1;
    bus.wr_data = d;
    bus.wr_mask = m;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wr_ready && n < 200);
    check("wr_accept", bus.wr_ready, 1);
    if (|m[3:0]) exp_q.push_back(d[31:0]);
    if (|m[7:4]) exp_q.push_back(d[63:32]);
    @(posedge clk);
    #1;
    bus.wr_valid = 0;
  endtask

  task automatic do_flush();
    bus.out_ready = 0;
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    exp_q.delete();
    wcnt = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 64'(exp_q.size()), 0);
    check("drain_level", level, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_valid = 0;
    bus.wr_data = 0;
    bus.wr_mask = 0;
    bus.out_ready = 0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_level", level, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("rst_wr_ready", bus.wr_ready, 1);
    // single store latency and ordering
    bus.out_ready = 1;
    push(64'h22222222_11111111, 8'hFF);
    @(negedge clk);
    check("t1_valid_k", bus.out_valid, 0);
    check("t1_level_k", level, 1);
    @(negedge clk);
    check("t1_valid_k1", bus.out_valid, 1);
    check("t1_data_k1", bus.out_data, 32'h11111111);
    @(negedge clk);
    check("t1_data_k2", bus.out_data, 32'h22222222);
    @(negedge clk);
    check("t1_valid_end", bus.out_valid, 0);
    check("t1_level_end", level, 0);
    @(posedge clk);
    #1;
    // four full stores: out_last only on the 8th word
    do_flush();
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) push({32'hA000_0001 + 32'(2*i+1), 32'hA000_0001 + 32'(2*i)}, 8'hFF);
    wait_drain();
    check("t2_count_wrapped", wcnt, 0);
    // partial masks, including an all-zero beat
    do_flush();
    bus.out_ready = 1;
    push(64'hB1B1B1B1_B0B0B0B0, 8'h0F);
    push(64'hB3B3B3B3_B2B2B2B2, 8'hF0);
    push(64'hB5B5B5B5_B4B4B4B4, 8'h00);
    push(64'hB7B7B7B7_B6B6B6B6, 8'h01);
    check("t3_expected_words", 64'(exp_q.size()) + 64'(wcnt), 3);
    wait_drain();
    check("t3_words_seen", wcnt, 3);
    // fill to full with the consumer stalled, then drain
    do_flush();
    for (int i = 0; i < DEPTH + 1; i++) push({32'hC100_0000 + 32'(i), 32'hC000_0000 + 32'(i)}, 8'hFF);
    bus.wr_valid = 1;
    bus.wr_data = 64'hDEADDEAD_DEADDEAD;
    bus.wr_mask = 8'hFF;
    @(negedge clk);
    check("t4_full_ready", bus.wr_ready, 0);
    check("t4_full_level", level, 16);
    @(posedge clk);
    #1;
    bus.wr_valid = 0;
    bus.out_ready = 1;
    @(negedge clk);
    check("t4_ready_pre", bus.wr_ready, 0);
    @(negedge clk);
    check("t4_ready_lo_hs", bus.wr_ready, 0);
    check("t4_level_lo_hs", level, 16);
    @(negedge clk);
    check("t4_ready_pop", bus.wr_ready, 1);
    check("t4_level_pop", level, 15);
    @(posedge clk);
    #1;
    wait_drain();
    // random consumer back-pressure
    do_flush();
    done = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) push({32'hD100_0000 + 32'(i), 32'hD000_0000 + 32'(i)}, (i % 3 == 0) ? 8'hFF : (i % 3 == 1) ? 8'h30 : 8'h0C);
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1;
    wait_drain();
    // flush while holding a high word with entries queued
    do_flush();
    for (int i = 0; i < 6; i++) push({32'hE100_0000 + 32'(i), 32'hE000_0000 + 32'(i)}, 8'hFF);
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    bus.out_ready = 0;
    @(negedge clk);
    check("t6_level_q", level, 5);
    check("t6_hi_valid", bus.out_valid, 1);
    check("t6_hi_data", bus.out_data, 32'hE1000000);
    @(posedge clk);
    #1;
    do_flush();
    @(negedge clk);
    check("t6_flush_valid", bus.out_valid, 0);
    check("t6_flush_level", level, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) push({32'hF100_0000 + 32'(i), 32'hF000_0000 + 32'(i)}, 8'hFF);
    wait_drain();
    check("t6_count_wrapped", wcnt, 0);
    // asynchronous reset mid-stream
    do_flush();
    for (int i = 0; i < 3; i++) push({32'h9100_0000 + 32'(i), 32'h9000_0000 + 32'(i)}, 8'hFF);
    @(negedge clk);
    check("t7_pre_valid", bus.out_valid, 1);
    check("t7_pre_level", level, 2);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("t7_async_valid", bus.out_valid, 0);
    check("t7_async_level", level, 0);
    check("t7_async_last", bus.out_last, 0);
    @(posedge clk);
    #1;
    rst = 0;
    exp_q.delete();
    wcnt = 0;
    bus.out_ready = 1;
    repeat (3) @(negedge clk);
    check("t7_post_valid", bus.out_valid, 0);
    check("t7_post_ready", bus.wr_ready, 1);
    @(posedge clk);
    #1;
    push(64'h87654321_12345678, 8'hFF);
    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
